// File: rtl/ofs_fim_emif_axi_mm_responder.sv
// ---------------------------------------------------------------------------
// ofs_fim_emif_axi_mm_responder
//
// Stand-in for the EMIF end of the memory-subsystem AXI-MM channel. AW/W/AR
// requests from a user-side initiator are served from an on-chip simple
// dual-port RAM, and B/R responses are returned. One write burst and one read
// burst are in flight at a time, on independent write and read engines.
// Only full-width INCR bursts are supported; size/burst/cache/prot/qos/user
// sidebands are not ported.
//
// Optional feature (compile-time macro OFS_FIM_EMIF_RESP_WLAST_CHK_EN):
//   defined   - a beat whose wlast disagrees with (beat count == awlen) sets a
//               sticky burst error and the burst answers SLVERR. The beat
//               count still ends the burst and data is still written.
//   undefined - wlast is ignored and bresp is always OKAY.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   aw*_i / awready_o        write address channel (id, byte addr, len)
//   w*_i  / wready_o         write data channel (data, strobes, last)
//   bvalid_o/bid_o/bresp_o   write response channel, bready_i
//   ar*_i / arready_o        read address channel (id, byte addr, len)
//   rvalid_o/rid_o/rdata_o/rresp_o/rlast_o  read data channel, rready_i
//   dbg_wr_state_o           write engine state
//   dbg_rd_state_o           read engine state
//
// Handshakes: a transfer happens on the rising clk edge where valid and ready
// are both 1. Outputs driven with valid stay stable until that edge; every
// ready/valid output here depends on engine state only, never on the peer's
// valid/ready in the same cycle.
// ---------------------------------------------------------------------------
module ofs_fim_emif_axi_mm_responder #(
  parameter int ID_WIDTH   = 9,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 8,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [ID_WIDTH-1:0]     awid_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic [LEN_WIDTH-1:0]    awlen_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  output logic [ID_WIDTH-1:0]     bid_o,
  output logic [1:0]              bresp_o,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  input  logic [ID_WIDTH-1:0]     arid_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic [LEN_WIDTH-1:0]    arlen_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [ID_WIDTH-1:0]     rid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rlast_o,
  output logic [1:0]              dbg_wr_state_o,
  output logic [1:0]              dbg_rd_state_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int B      = $clog2(STRB_W);
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  // *_RST states hold all readies low while reset is asserted and for the
  // edge that leaves reset, so awready/arready rise one cycle after release.
  typedef enum logic [1:0] {W_RST, W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_RST, R_IDLE, R_DATA}         rd_state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // ---------------- write engine ----------------
  wr_state_e             wr_state_q, wr_state_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d;
  logic [DEPTH_LOG2-1:0] widx_q, widx_d;
  logic [LEN_WIDTH-1:0]  wlen_q, wlen_d;
  logic [LEN_WIDTH-1:0]  wcnt_q, wcnt_d;
  logic                  werr_q, werr_d;
  logic                  mem_we;
  logic                  w_last_beat;

  always_comb begin
    wr_state_d  = wr_state_q;
    wid_d       = wid_q;
    widx_d      = widx_q;
    wlen_d      = wlen_q;
    wcnt_d      = wcnt_q;
    werr_d      = werr_q;
    mem_we      = 1'b0;
    awready_o   = 1'b0;
    wready_o    = 1'b0;
    bvalid_o    = 1'b0;
    w_last_beat = (wcnt_q == wlen_q);
    case (wr_state_q)
      W_RST: wr_state_d = W_IDLE;
      W_IDLE: begin
        awready_o = 1'b1;
        if (awvalid_i) begin
          wid_d      = awid_i;
          widx_d     = awaddr_i[DEPTH_LOG2+B-1:B];
          wlen_d     = awlen_i;
          wcnt_d     = '0;
          werr_d     = 1'b0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          mem_we = 1'b1;
          widx_d = widx_q + 1'b1;
          wcnt_d = wcnt_q + 1'b1;
`ifdef OFS_FIM_EMIF_RESP_WLAST_CHK_EN
          if (wlast_i != w_last_beat) werr_d = 1'b1;
`endif
          if (w_last_beat) wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid_o = 1'b1;
        if (bready_i) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_RST;
      wid_q      <= '0;
      widx_q     <= '0;
      wlen_q     <= '0;
      wcnt_q     <= '0;
      werr_q     <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wid_q      <= wid_d;
      widx_q     <= widx_d;
      wlen_q     <= wlen_d;
      wcnt_q     <= wcnt_d;
      werr_q     <= werr_d;
    end
  end

  assign bid_o   = wid_q;
  assign bresp_o = (bvalid_o && werr_q) ? 2'b10 : 2'b00;

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb_i[i]) mem_q[widx_q][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  rd_state_e             rd_state_q, rd_state_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DEPTH_LOG2-1:0] ridx_q, ridx_d;   // index of the next word to fetch
  logic [LEN_WIDTH-1:0]  rlen_q, rlen_d;
  logic [LEN_WIDTH-1:0]  rcnt_q, rcnt_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] ar_idx;

  assign ar_idx = araddr_i[DEPTH_LOG2+B-1:B];

  always_comb begin
    rd_state_d = rd_state_q;
    rid_d      = rid_q;
    ridx_d     = ridx_q;
    rlen_d     = rlen_q;
    rcnt_d     = rcnt_q;
    rd_en      = 1'b0;
    rd_idx     = ridx_q;
    arready_o  = 1'b0;
    rvalid_o   = 1'b0;
    rlast_o    = 1'b0;
    case (rd_state_q)
      R_RST: rd_state_d = R_IDLE;
      R_IDLE: begin
        arready_o = 1'b1;
        if (arvalid_i) begin
          rid_d      = arid_i;
          rlen_d     = arlen_i;
          rcnt_d     = '0;
          rd_en      = 1'b1;
          rd_idx     = ar_idx;
          ridx_d     = ar_idx + 1'b1;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        rvalid_o = 1'b1;
        rlast_o  = (rcnt_q == rlen_q);
        if (rready_i) begin
          if (rlast_o) begin
            rd_state_d = R_IDLE;
          end else begin
            // Prefetch the next beat on the accepting edge so beats stream.
            rd_en  = 1'b1;
            ridx_d = ridx_q + 1'b1;
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_RST;
      rid_q      <= '0;
      ridx_q     <= '0;
      rlen_q     <= '0;
      rcnt_q     <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rid_q      <= rid_d;
      ridx_q     <= ridx_d;
      rlen_q     <= rlen_d;
      rcnt_q     <= rcnt_d;
    end
  end

  // Registered read port: a same-cycle write to the same word is not yet
  // visible, so the old data is returned. Holding when rd_en=0 keeps rdata
  // stable through rready stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata_q <= '0;
    else if (rd_en) rdata_q <= mem_q[rd_idx];
  end

  assign rid_o   = rid_q;
  assign rdata_o = rdata_q;
  assign rresp_o = 2'b00;

  assign dbg_wr_state_o = wr_state_q;
  assign dbg_rd_state_o = rd_state_q;

  // Address bits outside the word index, and wlast when the check is off,
  // are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{awaddr_i, araddr_i, wlast_i};

endmodule

// File: tb/tb_ofs_fim_emif_axi_mm_responder.sv
module tb_ofs_fim_emif_axi_mm_responder;

  localparam int IDW = 9;
  localparam int AW  = 32;
  localparam int DW  = 512;
  localparam int LW  = 8;
  localparam int DL  = 6;
  localparam int NW  = 1 << DL;
  localparam int SW  = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           awvalid_i = 0, awready_o;
  logic [IDW-1:0] awid_i = 0;
  logic [AW-1:0]  awaddr_i = 0;
  logic [LW-1:0]  awlen_i = 0;
  logic           wvalid_i = 0, wready_o;
  logic [DW-1:0]  wdata_i = 0;
  logic [SW-1:0]  wstrb_i = 0;
  logic           wlast_i = 0;
  logic           bvalid_o, bready_i = 0;
  logic [IDW-1:0] bid_o;
  logic [1:0]     bresp_o;
  logic           arvalid_i = 0, arready_o;
  logic [IDW-1:0] arid_i = 0;
  logic [AW-1:0]  araddr_i = 0;
  logic [LW-1:0]  arlen_i = 0;
  logic           rvalid_o, rready_i = 0;
  logic [IDW-1:0] rid_o;
  logic [DW-1:0]  rdata_o;
  logic [1:0]     rresp_o;
  logic           rlast_o;
  logic [1:0]     dbg_wr_state_o, dbg_rd_state_o;

  ofs_fim_emif_axi_mm_responder #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .DEPTH_LOG2(DL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid_i(awvalid_i), .awready_o(awready_o), .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .bvalid_o(bvalid_o), .bready_i(bready_i), .bid_o(bid_o), .bresp_o(bresp_o),
    .arvalid_i(arvalid_i), .arready_o(arready_o), .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o),
    .rlast_o(rlast_o), .dbg_wr_state_o(dbg_wr_state_o), .dbg_rd_state_o(dbg_rd_state_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [DW-1:0] model [NW];     // expected memory contents, word-indexed
  logic [DW-1:0] exp_q [$];      // expected read beats in order
  logic [DW-1:0] wd_a [16];      // write burst data staged by the test
  logic [SW-1:0] ws_a [16];      // write burst strobes staged by the test

  localparam logic [1:0] BAD_WLAST_RESP =
`ifdef OFS_FIM_EMIF_RESP_WLAST_CHK_EN
    2'b10;
`else
    2'b00;
`endif

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int word_of(input logic [AW-1:0] addr);
    return int'(addr / SW) % NW;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len,
                          input int wlast_at, input logic [1:0] exp_resp);
    int n, beat, base, w;
    bit done;
    base = word_of(addr);
    @(negedge clk);
    awvalid_i = 1; awid_i = id; awaddr_i = addr; awlen_i = LW'(len);
    n = 0;
    while (!awready_o && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("aw_timeout", 1, 0);
    @(negedge clk);
    awvalid_i = 0;
    check("wready_after_aw", wready_o, 1);
    beat = 0; n = 0;
    while (beat <= len && n < 500) begin
      wvalid_i = ($urandom_range(0, 3) != 0);
      wdata_i  = wd_a[beat];
      wstrb_i  = ws_a[beat];
      wlast_i  = (beat == wlast_at);
      if (wvalid_i && wready_o) begin
        w = (base + beat) % NW;
        for (int b = 0; b < SW; b++)
          if (ws_a[beat][b]) model[w][b*8 +: 8] = wd_a[beat][b*8 +: 8];
        beat++;
      end
      @(negedge clk); n++;
    end
    wvalid_i = 0; wlast_i = 0;
    if (n >= 500) check("w_timeout", 1, 0);
    check("bvalid_after_last", bvalid_o, 1);
    done = 0; n = 0;
    while (!done && n < 100) begin
      bready_i = 1'($urandom_range(0, 1));
      check("bvalid_hold", bvalid_o, 1);
      check("bid", bid_o, id);
      check("bresp", bresp_o, exp_resp);
      if (bready_i && bvalid_o) done = 1;
      @(negedge clk); n++;
    end
    bready_i = 0;
    if (!done) check("b_timeout", 1, 0);
    check("awready_after_b", awready_o, 1);
  endtask

  task automatic do_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len,
                         input bit stall);
    int n, beat, base;
    base = word_of(addr);
    for (int b = 0; b <= len; b++) exp_q.push_back(model[(base + b) % NW]);
    @(negedge clk);
    arvalid_i = 1; arid_i = id; araddr_i = addr; arlen_i = LW'(len);
    n = 0;
    while (!arready_o && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("ar_timeout", 1, 0);
    @(negedge clk);
    arvalid_i = 0;
    check("rvalid_after_ar", rvalid_o, 1);
    beat = 0; n = 0;
    while (beat <= len && n < 600) begin
      rready_i = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rvalid_o) begin
        check("rid", rid_o, id);
        check("rlast", rlast_o, (beat == len));
        check("rresp", rresp_o, 0);
        check("rdata", rdata_o, exp_q[0]);
        if (rready_i) begin
          void'(exp_q.pop_front());
          beat++;
        end
      end
      @(negedge clk); n++;
    end
    rready_i = 0;
    if (n >= 600) check("r_timeout", 1, 0);
    exp_q.delete();
    check("rvalid_done", rvalid_o, 0);
    check("arready_after_r", arready_o, 1);
  endtask

  task automatic fill_full(input int len);
    for (int b = 0; b <= len; b++) begin
      for (int k = 0; k < DW / 32; k++) wd_a[b][k*32 +: 32] = $urandom;
      ws_a[b] = '1;
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_awready"}, awready_o, 0);
    check({tag, "_wready"},  wready_o, 0);
    check({tag, "_bvalid"},  bvalid_o, 0);
    check({tag, "_arready"}, arready_o, 0);
    check({tag, "_rvalid"},  rvalid_o, 0);
    check({tag, "_rlast"},   rlast_o, 0);
    check({tag, "_bid"},     bid_o, 0);
    check({tag, "_rdata"},   rdata_o, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n, base, len;
    logic [IDW-1:0] id;

    repeat (3) @(negedge clk);
    check_idle_reset("rst");
    rst_n = 1;
    @(negedge clk);
    check("awready_post_rst", awready_o, 1);
    check("arready_post_rst", arready_o, 1);

    // W offered before any AW must stall
    wvalid_i = 1;
    @(negedge clk);
    check("wready_early", wready_o, 0);
    wvalid_i = 0;

    // basic burst at index 1
    for (int b = 0; b < 4; b++) begin wd_a[b] = DW'(8'hA0 + b); ws_a[b] = '1; end
    do_write(9'h15A, 32'h40, 3, 3, 2'b00);
    do_read(9'h0C3, 32'h40, 3, 0);

    // partial strobe
    wd_a[0] = '1; ws_a[0] = '1;
    do_write(9'h001, 32'h100, 0, 0, 2'b00);
    wd_a[0] = '0; ws_a[0] = SW'(1);
    do_write(9'h002, 32'h100, 0, 0, 2'b00);
    check("partial_model", model[4], {{(DW-8){1'b1}}, 8'h00});
    do_read(9'h003, 32'h100, 0, 0);

    // wrap from last word to word 0
    fill_full(1);
    do_write(9'h1FF, 32'((NW - 1) * SW), 1, 1, 2'b00);
    do_read(9'h004, 32'h0, 0, 0);
    do_read(9'h005, 32'((NW - 1) * SW), 1, 1);

    // wlast on the wrong beat
    fill_full(3);
    do_write(9'h0AA, 32'h200, 3, 2, BAD_WLAST_RESP);
    do_read(9'h0AB, 32'h200, 3, 0);

    // 16-beat bursts with backpressure
    fill_full(15);
    do_write(9'h077, 32'h400, 15, 15, 2'b00);
    do_read(9'h078, 32'h400, 15, 1);

    // randomized full write, random-strobe overwrite, stalled read-back
    for (int it = 0; it < 6; it++) begin
      base = $urandom_range(0, NW - 1);
      len  = $urandom_range(0, 15);
      id   = IDW'($urandom);
      fill_full(len);
      do_write(id, 32'(base * SW), len, len, 2'b00);
      for (int b = 0; b <= len; b++) begin
        for (int k = 0; k < DW / 32; k++) wd_a[b][k*32 +: 32] = $urandom;
        ws_a[b] = {$urandom, $urandom};
      end
      do_write(id + 1'b1, 32'(base * SW), len, len, 2'b00);
      do_read(id ^ 9'h155, 32'(base * SW), len, 1);
    end

    // concurrent write (words 48..51) and read (words 16..19)
    fill_full(3);
    do_write(9'h010, 32'(16 * SW), 3, 3, 2'b00);
    fill_full(3);
    fork
      do_write(9'h011, 32'(48 * SW), 3, 3, 2'b00);
      do_read(9'h012, 32'(16 * SW), 3, 1);
    join
    do_read(9'h013, 32'(48 * SW), 3, 0);

    // reset during beat 2 of an 8-beat read
    fill_full(7);
    do_write(9'h0F0, 32'(20 * SW), 7, 7, 2'b00);
    @(negedge clk);
    arvalid_i = 1; arid_i = 9'h0F1; araddr_i = 32'(20 * SW); arlen_i = 8'd7;
    n = 0;
    while (!arready_o && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid_i = 0;
    rready_i = 1;
    repeat (2) @(negedge clk);
    check("rst_mid_rvalid", rvalid_o, 1);
    rst_n = 0;
    #1;
    check_idle_reset("midrst");
    rready_i = 0;
    repeat (2) @(negedge clk);
    check_idle_reset("midrst_hold");
    rst_n = 1;
    @(negedge clk);
    check("awready_after_midrst", awready_o, 1);
    check("arready_after_midrst", arready_o, 1);
    fill_full(2);
    do_write(9'h0F2, 32'(30 * SW), 2, 2, 2'b00);
    do_read(9'h0F3, 32'(30 * SW), 2, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
